// File: rtl/cmd_parser_pkg.sv
// Shared constants for the SUMP command parser: framing bit, argument length
// and FSM state encodings.
package cmd_parser_pkg;

    localparam int LONG_CMD_BIT = 7;
    localparam int DATA_BYTES   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;

    function automatic logic is_long_cmd(input logic [7:0] b);
        return b[LONG_CMD_BIT];
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Saturating inter-byte timeout counter; expire fires in the last allowed
// idle cycle unless that cycle also clears the count.
module cmd_timeout #(
    parameter int TIMEOUT = 1000000,
    parameter int TW      = 20
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam logic [TW-1:0] LP_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] LP_MAX  = '1;

    logic [TW-1:0] r_count;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_count <= '0;
        end else if (clr || (TIMEOUT == 0)) begin
            r_count <= '0;
        end else if (run && (r_count != LP_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A clearing byte in the same cycle wins over expiry.
    assign expire = (TIMEOUT != 0) && run && !clr && (r_count == LP_LAST);

endmodule

// File: rtl/cmd_parser.sv
// SUMP framing: short commands (bit7=0) execute immediately, long commands
// collect four LSB-first argument bytes before executing.
module cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int TIMEOUT = 1000000,
    parameter int TW      = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  opcode,
    output logic [31:0] config_data,
    output logic        execute,
    output logic        timeout_err,
    output logic        parse_busy
);

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_op_hold;
    logic [7:0]  r_opcode;
    logic [31:0] r_config;
    logic        r_timeout_err;

    logic        w_accept;
    logic        w_in_data;
    logic        w_start_long;
    logic        w_last;
    logic        w_expire;
    logic [31:0] w_shift;

    assign w_accept     = rx_valid && rx_ready;
    assign w_in_data    = (r_state == ST_DATA);
    assign w_start_long = (r_state == ST_IDLE) && w_accept && is_long_cmd(rx_data);
    assign w_last       = w_in_data && w_accept && (r_idx == 2'(DATA_BYTES - 1));

    // w_shift already includes the byte being accepted, so the final lane
    // can be captured straight into config_data on the completing cycle.
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
        logic [7:0] r_lane;

        assign w_shift[gi*8 +: 8] =
            (w_in_data && w_accept && (r_idx == 2'(gi))) ? rx_data : r_lane;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_lane <= '0;
            end else if (w_start_long) begin
                r_lane <= '0;
            end else begin
                r_lane <= w_shift[gi*8 +: 8];
            end
        end
    end

    cmd_timeout #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timeout (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (w_accept || !w_in_data),
        .run       (w_in_data && !w_accept),
        .expire    (w_expire)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_op_hold     <= '0;
            r_opcode      <= '0;
            r_config      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_expire;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_long_cmd(rx_data)) begin
                            r_op_hold <= rx_data;
                            r_idx     <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_opcode  <= rx_data;
                            r_config  <= '0;
                            r_state   <= ST_EXEC;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_opcode <= r_op_hold;
                            r_config <= w_shift;
                            r_idx    <= '0;
                            r_state  <= ST_EXEC;
                        end
                    end else if (w_expire) begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready    = (r_state != ST_EXEC);
    assign execute     = (r_state == ST_EXEC);
    assign parse_busy  = w_in_data;
    assign opcode      = r_opcode;
    assign config_data = r_config;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: a byte-level SUMP model predicts execute
// and timeout events; a monitor pops and compares them as the DUT emits them.
module tb_cmd_parser;

    localparam int TO = 16;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_valid  = 1'b0;
    logic        rx_ready;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        timeout_err;
    logic        parse_busy;

    cmd_parser #(
        .TIMEOUT (TO),
        .TW      (8)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .opcode      (opcode),
        .config_data (config_data),
        .execute     (execute),
        .timeout_err (timeout_err),
        .parse_busy  (parse_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        is_to;
        logic [7:0]  op;
        logic [31:0] cfg;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  last_exec_cyc = -100;
    int  prev_exec_cyc = -100;

    // Reference model: -1 when no long command is open, else data bytes seen.
    int          m_cnt = -1;
    logic [7:0]  m_op;
    logic [7:0]  m_data [4];
    logic [7:0]  m_last_op  = 8'h00;
    logic [31:0] m_last_cfg = 32'h0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input logic is_to, input logic [7:0] op, input logic [31:0] cfg);
        ev_t e;
        e.is_to = is_to;
        e.op    = op;
        e.cfg   = cfg;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_cnt      = -1;
        m_last_op  = 8'h00;
        m_last_cfg = 32'h0;
    endtask

    // gap = idle cycles since the previous accepted byte.
    task automatic model_byte(input logic [7:0] b, input int gap, output logic exp_busy);
        if (m_cnt >= 0 && gap >= TO) begin
            push_ev(1'b1, m_last_op, m_last_cfg);
            m_cnt = -1;
        end
        exp_busy = (m_cnt >= 0);
        if (m_cnt < 0) begin
            if (!b[7]) begin
                m_last_op  = b;
                m_last_cfg = 32'h0;
                push_ev(1'b0, m_last_op, m_last_cfg);
            end else begin
                m_op  = b;
                m_cnt = 0;
            end
        end else begin
            m_data[m_cnt] = b;
            m_cnt++;
            if (m_cnt == 4) begin
                m_last_op  = m_op;
                m_last_cfg = {m_data[3], m_data[2], m_data[1], m_data[0]};
                push_ev(1'b0, m_last_op, m_last_cfg);
                m_cnt = -1;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic exp_busy;
        logic acc;
        logic busy_s;
        int   tries;
        model_byte(b, gap, exp_busy);
        rx_valid = 1'b0;
        repeat (gap) @(posedge sys_clk);
        if (gap > 0) #1;
        rx_valid = 1'b1;
        rx_data  = b;
        tries    = 0;
        acc      = 1'b0;
        busy_s   = 1'b0;
        while (!acc && tries < 50) begin
            @(negedge sys_clk);
            acc    = rx_ready;
            busy_s = parse_busy;
            @(posedge sys_clk);
            #1;
            tries++;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte %0h not accepted, required within 50 cycles", b);
        end else begin
            check("parse_busy", {31'b0, busy_s}, {31'b0, exp_busy});
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && (execute || timeout_err)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: exec=%0b terr=%0b op=%0h cfg=%0h, required none",
                         execute, timeout_err, opcode, config_data);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_is_timeout", {31'b0, timeout_err}, {31'b0, e.is_to});
                check("event_is_execute", {31'b0, execute}, {31'b0, !e.is_to});
                check("opcode", {24'b0, opcode}, {24'b0, e.op});
                check("config_data", config_data, e.cfg);
                if (execute) check("rx_ready_in_exec", {31'b0, rx_ready}, 32'd0);
            end
            if (execute) begin
                prev_exec_cyc = last_exec_cyc;
                last_exec_cyc = cyc;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_opcode"}, {24'b0, opcode}, 32'h0);
        check({tag, "_config"}, config_data, 32'h0);
        check({tag, "_execute"}, {31'b0, execute}, 32'd0);
        check({tag, "_timeout_err"}, {31'b0, timeout_err}, 32'd0);
        check({tag, "_parse_busy"}, {31'b0, parse_busy}, 32'd0);
        check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd1);
    endtask

    initial begin
        #1;
        check_reset_values("reset");
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();

        // Short command, then a long command.
        send_byte(8'h01, 2);
        send_byte(8'hC0, 2);
        send_byte(8'h78, 0);
        send_byte(8'h56, 1);
        send_byte(8'h34, 0);
        send_byte(8'h12, 2);

        // Back-to-back short commands: second one stalls during EXEC.
        send_byte(8'h02, 3);
        send_byte(8'h11, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        check("exec_spacing", last_exec_cyc - prev_exec_cyc, 32'd2);

        // Truncated long command times out; next byte parses normally.
        send_byte(8'h80, 2);
        send_byte(8'hAA, 0);
        send_byte(8'h01, TO);

        // Byte arriving in the expiry cycle wins.
        send_byte(8'h90, 1);
        send_byte(8'h01, 0);
        send_byte(8'h02, TO - 1);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);

        // Zero bytes inside a long command are data; a trailing 0x00 is a short command.
        send_byte(8'h80, 2);
        for (int i = 0; i < 5; i++) send_byte(8'h00, 0);

        // Asynchronous reset mid-command.
        send_byte(8'h85, 3);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        sys_rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        send_byte(8'h81, 1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);

        // Random byte stream with occasional long idle gaps.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            int g;
            b = 8'($urandom_range(0, 255));
            g = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 2);
            send_byte(b, g);
        end

        repeat (TO + 20) @(posedge sys_clk);
        #1;
        check("events_outstanding", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
